// File: rtl/scoot_world.sv
// Grid-world environment for scootBot: a toroidal food bitmap, the bot position and its four
// look sensors, stepped as EAT -> SENSE -> WAIT(STEP_CYCLES) -> MOVE until NUM_STEPS moves are done.
module scoot_world #(
  parameter int                WIDTH       = 10,
  parameter int                HEIGHT      = 10,
  parameter int                NUM_STEPS   = 100,
  parameter int                STEP_CYCLES = 8,
  parameter logic [HEIGHT-1:0] ROW_PATTERN = 10'b0010101001,
  parameter int                XW          = $clog2(WIDTH),
  parameter int                YW          = $clog2(HEIGHT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          m_up,
  input  logic          m_right,
  input  logic          m_down,
  input  logic          m_left,
  output logic          l_up,
  output logic          l_right,
  output logic          l_down,
  output logic          l_left,
  output logic [XW-1:0] pos_x,
  output logic [YW-1:0] pos_y,
  output logic [15:0]   score,
  output logic [15:0]   step_count,
  output logic          picked_up,
  output logic          busy,
  output logic          done
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] EAT   = 3'd1;
  localparam logic [2:0] SENSE = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] MOVE  = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  localparam int            CW       = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] WCNT_MAX = CW'(STEP_CYCLES - 1);
  localparam logic [XW-1:0] X_MAX    = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX    = YW'(HEIGHT - 1);
  localparam logic [XW-1:0] X_START  = XW'(WIDTH / 2);
  localparam logic [YW-1:0] Y_START  = YW'(HEIGHT / 2);
  localparam logic [15:0]   STEP_END = 16'(NUM_STEPS);

  logic [2:0]        r_state;
  logic [CW-1:0]     r_wcnt;
  logic [HEIGHT-1:0] r_grid [WIDTH];
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [15:0]       r_score;
  logic [15:0]       r_step;
  logic              r_lu, r_lr, r_ld, r_ll;
  logic              r_picked, r_busy, r_done;

  logic [XW-1:0]     w_xp, w_xm, w_nx;
  logic [YW-1:0]     w_yp, w_ym, w_ny;
  logic              w_here;
  logic [15:0]       w_step_inc;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Wrapped neighbour coordinates of the current position
  assign w_xp       = (r_x == X_MAX) ? '0 : r_x + 1'b1;
  assign w_xm       = (r_x == '0) ? X_MAX : r_x - 1'b1;
  assign w_yp       = (r_y == Y_MAX) ? '0 : r_y + 1'b1;
  assign w_ym       = (r_y == '0) ? Y_MAX : r_y - 1'b1;
  assign w_here     = r_grid[r_x][r_y];
  assign w_step_inc = r_step + 16'd1;

  // Opposing requests cancel; x and y are resolved independently so diagonals work
  always_comb begin
    w_nx = r_x;
    w_ny = r_y;
    if (m_right && !m_left) w_nx = w_xp;
    else if (m_left && !m_right) w_nx = w_xm;
    if (m_up && !m_down) w_ny = w_yp;
    else if (m_down && !m_up) w_ny = w_ym;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_wcnt   <= '0;
      for (int i = 0; i < WIDTH; i++) r_grid[i] <= ROW_PATTERN;
      r_x      <= X_START;
      r_y      <= Y_START;
      r_score  <= 16'd0;
      r_step   <= 16'd0;
      r_lu     <= 1'b0;
      r_lr     <= 1'b0;
      r_ld     <= 1'b0;
      r_ll     <= 1'b0;
      r_picked <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_picked <= 1'b0;
      r_busy   <= (r_state == EAT) || (r_state == SENSE) ||
                  (r_state == WAIT) || (r_state == MOVE);
      r_done   <= (r_state == DONE);
      case (r_state)
        IDLE: begin
          if (start) r_state <= EAT;
        end
        EAT: begin
          if (w_here) begin
            r_grid[r_x][r_y] <= 1'b0;
            r_score          <= sat_inc16(r_score);
            r_picked         <= 1'b1;
          end
          r_state <= SENSE;
        end
        SENSE: begin
          r_lu    <= r_grid[r_x][w_yp];
          r_lr    <= r_grid[w_xp][r_y];
          r_ld    <= r_grid[r_x][w_ym];
          r_ll    <= r_grid[w_xm][r_y];
          r_wcnt  <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (r_wcnt == WCNT_MAX) r_state <= MOVE;
          else r_wcnt <= r_wcnt + 1'b1;
        end
        MOVE: begin
          r_x     <= w_nx;
          r_y     <= w_ny;
          r_step  <= w_step_inc;
          r_state <= (w_step_inc == STEP_END) ? DONE : EAT;
        end
        DONE: begin
          r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign l_up       = r_lu;
  assign l_right    = r_lr;
  assign l_down     = r_ld;
  assign l_left     = r_ll;
  assign pos_x      = r_x;
  assign pos_y      = r_y;
  assign score      = r_score;
  assign step_count = r_step;
  assign picked_up  = r_picked;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_scoot_world.sv
// Bench for scoot_world: a step-level world model predicts every output on every cycle of a run,
// with hand-computed end-of-run and timing literals alongside.
module tb_scoot_world;

  localparam int W   = 10;
  localparam int H   = 10;
  localparam int N   = 100;
  localparam int SC  = 8;
  localparam int SL  = SC + 3;
  localparam int END = N * SL;

  logic        clk = 1'b0;
  logic        reset, start, m_up, m_right, m_down, m_left;
  logic        l_up, l_right, l_down, l_left;
  logic [3:0]  pos_x, pos_y;
  logic [15:0] score, step_count;
  logic        picked_up, busy, done;

  int errors = 0;
  int checks = 0;

  int         ex_x  [0:N];
  int         ex_y  [0:N];
  int         ex_sc [0:N-1];
  int         ex_pk [0:N-1];
  logic [3:0] ex_l  [0:N-1];

  always #5 clk = ~clk;

  scoot_world #(
    .WIDTH(W), .HEIGHT(H), .NUM_STEPS(N), .STEP_CYCLES(SC),
    .ROW_PATTERN(10'b0010101001), .XW(4), .YW(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .m_up(m_up), .m_right(m_right), .m_down(m_down), .m_left(m_left),
    .l_up(l_up), .l_right(l_right), .l_down(l_down), .l_left(l_left),
    .pos_x(pos_x), .pos_y(pos_y), .score(score), .step_count(step_count),
    .picked_up(picked_up), .busy(busy), .done(done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Whole-run prediction: per step, position before the step, score/pickup after the eat,
  // and the four sensor bits seen after the eat.
  task automatic build_model(input int dx, input int dy);
    bit         g [W][H];
    logic [H-1:0] rp;
    int x, y, sc;
    rp = 10'b0010101001;
    x = W / 2;
    y = H / 2;
    sc = 0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < H; j++) g[i][j] = rp[j];
    for (int k = 0; k < N; k++) begin
      ex_x[k]  = x;
      ex_y[k]  = y;
      ex_pk[k] = 0;
      if (g[x][y]) begin
        g[x][y]  = 1'b0;
        sc++;
        ex_pk[k] = 1;
      end
      ex_sc[k] = sc;
      ex_l[k]  = {g[x][(y + 1) % H], g[(x + 1) % W][y], g[x][(y + H - 1) % H], g[(x + W - 1) % W][y]};
      x = (x + dx + W) % W;
      y = (y + dy + H) % H;
    end
    ex_x[N] = x;
    ex_y[N] = y;
  endtask

  // Expected outputs after edge n, where edge 0 is the one that samples start
  task automatic check_cycle(input string tag, input int n);
    int k, ph, ex, ey, esc, est, epk, ebusy, edone;
    logic [3:0] el;
    if (n == 0) begin
      ex = W / 2; ey = H / 2; esc = 0; est = 0; epk = 0; ebusy = 0; edone = 0; el = 4'b0000;
    end else if (n <= END) begin
      k = (n - 1) / SL;
      ph = (n - 1) % SL;
      ebusy = 1;
      edone = 0;
      esc = ex_sc[k];
      epk = (ph == 0) ? ex_pk[k] : 0;
      if (ph == 0) el = (k > 0) ? ex_l[k - 1] : 4'b0000;
      else el = ex_l[k];
      if (ph == SL - 1) begin
        ex = ex_x[k + 1]; ey = ex_y[k + 1]; est = k + 1;
      end else begin
        ex = ex_x[k]; ey = ex_y[k]; est = k;
      end
    end else begin
      ex = ex_x[N]; ey = ex_y[N]; esc = ex_sc[N - 1]; est = N; epk = 0;
      ebusy = 0; edone = 1; el = ex_l[N - 1];
    end
    chk($sformatf("%s pos_x n=%0d", tag, n), 32'(pos_x), ex);
    chk($sformatf("%s pos_y n=%0d", tag, n), 32'(pos_y), ey);
    chk($sformatf("%s score n=%0d", tag, n), 32'(score), esc);
    chk($sformatf("%s step_count n=%0d", tag, n), 32'(step_count), est);
    chk($sformatf("%s picked_up n=%0d", tag, n), 32'(picked_up), epk);
    chk($sformatf("%s look n=%0d", tag, n), 32'({l_up, l_right, l_down, l_left}), 32'(el));
    chk($sformatf("%s busy n=%0d", tag, n), 32'(busy), ebusy);
    chk($sformatf("%s done n=%0d", tag, n), 32'(done), edone);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " rst pos_x"}, 32'(pos_x), 5);
    chk({tag, " rst pos_y"}, 32'(pos_y), 5);
    chk({tag, " rst score"}, 32'(score), 0);
    chk({tag, " rst step_count"}, 32'(step_count), 0);
    chk({tag, " rst look"}, 32'({l_up, l_right, l_down, l_left}), 0);
    chk({tag, " rst picked_up"}, 32'(picked_up), 0);
    chk({tag, " rst busy"}, 32'(busy), 0);
    chk({tag, " rst done"}, 32'(done), 0);
  endtask

  task automatic run(input string tag, input logic mu, input logic mr, input logic md,
                     input logic ml, input int abort_n, input int fsc, input int fx, input int fy);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check_reset_values(tag);
    m_up = mu; m_right = mr; m_down = md; m_left = ml;
    build_model(int'(mr) - int'(ml), int'(mu) - int'(md));
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check_cycle(tag, 0);
    for (int n = 1; n <= END + 6; n++) begin
      if (n == abort_n) begin
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_reset_values({tag, " abort"});
        return;
      end
      start = (n == END + 3);
      @(posedge clk);
      @(negedge clk);
      check_cycle(tag, n);
      if (n == 1) begin
        chk({tag, " first eat score"}, 32'(score), 1);
        chk({tag, " first eat pulse"}, 32'(picked_up), 1);
      end
      if (n == 2) chk({tag, " first look"}, 32'({l_up, l_right, l_down, l_left}), 32'(4'b0101));
      if (n == END) chk({tag, " done before 1101"}, 32'(done), 0);
      if (n == END + 1) chk({tag, " done at 1101"}, 32'(done), 1);
    end
    start = 1'b0;
    chk({tag, " final score"}, 32'(score), fsc);
    chk({tag, " final pos_x"}, 32'(pos_x), fx);
    chk({tag, " final pos_y"}, 32'(pos_y), fy);
    chk({tag, " final steps"}, 32'(step_count), N);
    chk({tag, " final done"}, 32'(done), 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    m_up = 1'b0; m_right = 1'b0; m_down = 1'b0; m_left = 1'b0;
    repeat (2) @(posedge clk);
    run("left",   1'b0, 1'b0, 1'b0, 1'b1, -1, 10, 5, 5);
    run("down",   1'b0, 1'b0, 1'b1, 1'b0, -1, 4, 5, 5);
    run("cancel", 1'b0, 1'b1, 1'b0, 1'b1, -1, 1, 5, 5);
    run("diag",   1'b1, 1'b1, 1'b0, 1'b0, -1, 4, 5, 5);
    // Edge 413 falls in the WAIT of step 37 (0-based); the grid must come back whole
    run("abort",  1'b0, 1'b0, 1'b0, 1'b1, 1 + 37 * SL + 5, 0, 0, 0);
    run("left2",  1'b0, 1'b0, 1'b0, 1'b1, -1, 10, 5, 5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
